// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button conditioner: depth of the metastability synchronizer.
package button_conditioner_pkg;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_channel.sv
// One input bit: press-side saturating debounce plus registered level and edge pulses.
module debounce_channel #(
    parameter int unsigned PULSE_CNT_MAX = 150
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_bit,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned SAT_W = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [SAT_W-1:0] SAT_MAX = SAT_W'(PULSE_CNT_MAX);

    if (PULSE_CNT_MAX < 1) begin : g_bad_pulse_cnt
        $error("PULSE_CNT_MAX must be at least 1");
    end

    logic [SAT_W-1:0] sat_cnt;
    logic             hit;

    assign hit = (sat_cnt == SAT_MAX);

    // A single low sample restarts qualification; clearing takes priority over a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (!sync_bit) begin
            sat_cnt <= '0;
        end else if (tick && !hit) begin
            sat_cnt <= sat_cnt + SAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            level <= hit;
            rise  <= hit & ~level;
            fall  <= ~hit & level;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes raw board inputs, debounces presses on a shared sample tick,
// and produces a clean level with single-cycle rise/fall pulses per bit.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH          = 1,
    parameter int unsigned SAMPLE_CNT_MAX = 25000,
    parameter int unsigned PULSE_CNT_MAX  = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int unsigned TICK_W = $clog2(SAMPLE_CNT_MAX);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CNT_MAX - 1);

    if (SAMPLE_CNT_MAX < 2) begin : g_bad_sample_cnt
        $error("SAMPLE_CNT_MAX must be at least 2");
    end

    logic [WIDTH-1:0]  sync_pipe [SYNC_STAGES];
    logic [WIDTH-1:0]  sync;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_pipe[s] <= '0;
            end
        end else begin
            sync_pipe[0] <= async_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_pipe[s] <= sync_pipe[s-1];
            end
        end
    end

    assign sync = sync_pipe[SYNC_STAGES-1];

    // Free-running sample-rate divider shared by every channel.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .PULSE_CNT_MAX(PULSE_CNT_MAX)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .sync_bit (sync[i]),
            .tick     (tick),
            .level    (level_out[i]),
            .rise     (rise_pulse[i]),
            .fall     (fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: each input change queues its expected
// pulse with a cycle window, and a monitor pops and checks pulses as they appear.
module tb_button_conditioner;

    localparam int unsigned WIDTH = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] async_in;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;

    typedef struct {
        bit is_rise;
        int lo;
        int hi;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    bit  found;

    button_conditioner #(
        .WIDTH          (WIDTH),
        .SAMPLE_CNT_MAX (4),
        .PULSE_CNT_MAX  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .async_in   (async_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic push_ev(input int b, input bit is_rise, input int lo, input int hi);
        ev_t ev;
        ev.is_rise = is_rise;
        ev.lo      = lo;
        ev.hi      = hi;
        if (b == 0) q0.push_back(ev);
        else        q1.push_back(ev);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Match one bit's observed pulses against the head of its expectation queue.
    task automatic mon_bit(input int b, input logic r, input logic f, input logic lvl);
        ev_t ev;
        int  n;
        n = (b == 0) ? q0.size() : q1.size();
        if (r === 1'b1 || f === 1'b1) begin
            check($sformatf("excl_b%0d", b), 32'(r & f), 0);
            if (n == 0) begin
                check($sformatf("unexpected_pulse_b%0d", b), 32'({r, f}), 0);
            end else begin
                if (b == 0) ev = q0.pop_front();
                else        ev = q1.pop_front();
                check($sformatf("kind_b%0d", b), 32'(r), 32'(ev.is_rise));
                check($sformatf("time_b%0d", b), cyc, clamp(cyc, ev.lo, ev.hi));
                check($sformatf("level_at_pulse_b%0d", b), 32'(lvl), 32'(ev.is_rise));
            end
        end else if (n > 0) begin
            ev = (b == 0) ? q0[0] : q1[0];
            if (cyc > ev.hi) begin
                check($sformatf("missing_pulse_b%0d", b), 32'({r, f}), ev.is_rise ? 2 : 1);
                if (b == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int b = 0; b < WIDTH; b++) begin
                mon_bit(b, rise_pulse[b], fall_pulse[b], level_out[b]);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        async_in = '0;
        wait_cyc(3);
        check("rst_level", level_out, 0);
        check("rst_rise", rise_pulse, 0);
        check("rst_fall", fall_pulse, 0);
        rst = 1'b0;
        wait_cyc(5);

        // Clean press on bit 0.
        async_in = 2'b01;
        push_ev(0, 1'b1, cyc + 12, cyc + 15);
        wait_cyc(20);
        check("press_level", level_out, 2'b01);
        check("press_pending", q0.size() + q1.size(), 0);

        async_in = 2'b00;
        push_ev(0, 1'b0, cyc + 4, cyc + 4);
        wait_cyc(8);
        check("release_level", level_out, 2'b00);

        // One-cycle glitch low during accumulation restarts qualification.
        async_in = 2'b01;
        wait_cyc(6);
        async_in = 2'b00;
        wait_cyc(1);
        async_in = 2'b01;
        push_ev(0, 1'b1, cyc + 12, cyc + 15);
        wait_cyc(20);
        check("bounce_level", level_out, 2'b01);
        async_in = 2'b00;
        push_ev(0, 1'b0, cyc + 4, cyc + 4);
        wait_cyc(8);
        check("bounce_release_level", level_out, 2'b00);

        // Staggered presses, then a shared release.
        async_in = 2'b01;
        push_ev(0, 1'b1, cyc + 12, cyc + 15);
        wait_cyc(5);
        async_in = 2'b11;
        push_ev(1, 1'b1, cyc + 12, cyc + 15);
        wait_cyc(20);
        check("stagger_level", level_out, 2'b11);
        check("stagger_pending", q0.size() + q1.size(), 0);
        async_in = 2'b00;
        push_ev(0, 1'b0, cyc + 4, cyc + 4);
        push_ev(1, 1'b0, cyc + 4, cyc + 4);
        wait_cyc(8);
        check("stagger_release_level", level_out, 2'b00);

        // Simultaneous press qualifies both bits on the same edge.
        async_in = 2'b11;
        push_ev(0, 1'b1, cyc + 12, cyc + 15);
        push_ev(1, 1'b1, cyc + 12, cyc + 15);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (rise_pulse != '0) found = 1'b1;
        end
        check("simul_rise", rise_pulse, 2'b11);
        @(negedge clk);
        check("simul_rise_end", rise_pulse, 2'b00);
        wait_cyc(5);
        check("simul_level", level_out, 2'b11);

        // Asynchronous reset mid-cycle while inputs stay held.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_level", level_out, 0);
        check("midrst_rise", rise_pulse, 0);
        check("midrst_fall", fall_pulse, 0);
        wait_cyc(20);
        check("midrst_hold_level", level_out, 0);
        check("midrst_hold_fall", fall_pulse, 0);
        rst = 1'b0;
        push_ev(0, 1'b1, cyc + 13, cyc + 16);
        push_ev(1, 1'b1, cyc + 13, cyc + 16);
        wait_cyc(20);
        check("requal_level", level_out, 2'b11);
        check("requal_pending", q0.size() + q1.size(), 0);

        async_in = 2'b00;
        push_ev(0, 1'b0, cyc + 4, cyc + 4);
        push_ev(1, 1'b0, cyc + 4, cyc + 4);
        wait_cyc(8);
        check("final_level", level_out, 2'b00);
        check("final_pending", q0.size() + q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
